// File: rtl/four_func_calc_core_if.sv
// Button, operand and display signals between the debouncers, the calculator core and
// the display driver.
interface four_func_calc_core_if #(
  parameter int unsigned W = 11
);
  logic         Equals;
  logic         Add;
  logic         Subtract;
  logic         Multiply;
  logic         Divide;
  logic [W-1:0] Number;
  logic [W-1:0] Result;
  logic         Overflow;

  modport master (
    output Equals, Add, Subtract, Multiply, Divide, Number,
    input  Result, Overflow
  );

  modport slave (
    input  Equals, Add, Subtract, Multiply, Divide, Number,
    output Result, Overflow
  );
endinterface

// File: rtl/four_func_calc_core.sv
// Integer four-function calculator: signed accumulator, edge-detected buttons,
// sign-magnitude operand input, iterative shift-add multiply and restoring divide.
module four_func_calc_core #(
  parameter int unsigned W = 11
) (
  input logic                   Clock,
  input logic                   Clear,
  four_func_calc_core_if.slave  bus
);

  localparam int unsigned PW   = 2 * W;
  localparam int unsigned CntW = $clog2(W + 1);
  // Largest magnitude allowed for a negative / non-negative result.
  localparam logic [PW-1:0] NegLim = PW'(1) << (W - 1);
  localparam logic [PW-1:0] PosLim = NegLim - PW'(1);

  typedef enum logic [1:0] {StIdle, StOpsel, StBusy, StErr} state_e;
  typedef enum logic [2:0] {OpNone, OpAdd, OpSub, OpMul, OpDiv} op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [4:0]      btn_q, btn_d;
  logic [W-1:0]    res_q, res_d;
  logic            ovf_q, ovf_d;
  // Mul: x = shifted multiplicand, y = multiplier, z = product.
  // Div: x = divisor, y = dividend shifting out / quotient shifting in, z = remainder.
  logic [PW-1:0]   x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [PW-1:0]   z_q, z_d;
  logic            neg_q, neg_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [4:0]      btn_now, rise;
  logic            op_pressed;
  op_e             op_sel;
  logic [W-1:0]    num_mag, num_tc, a_mag;
  logic [W:0]      sum_add, sum_sub;
  logic            add_ovf, sub_ovf;
  logic [W:0]      rem_sh, dvs;
  logic            rem_ge;
  logic [PW-1:0]   fin_mag;
  logic            fin_ovf;
  logic [W-1:0]    fin_val;

  // Button bit order: Equals, Add, Subtract, Multiply, Divide (priority high to low).
  assign btn_now    = {bus.Equals, bus.Add, bus.Subtract, bus.Multiply, bus.Divide};
  assign rise       = btn_now & ~btn_q;
  assign op_pressed = |rise[3:0];

  // Pick the highest-priority operator among new presses.
  always_comb begin
    op_sel = OpDiv;
    if (rise[3])      op_sel = OpAdd;
    else if (rise[2]) op_sel = OpSub;
    else if (rise[1]) op_sel = OpMul;
  end

  // Operand conversion and single-cycle add/subtract with one guard bit.
  assign num_mag = {1'b0, bus.Number[W-2:0]};
  assign num_tc  = bus.Number[W-1] ? -num_mag : num_mag;
  assign a_mag   = res_q[W-1] ? -res_q : res_q;
  assign sum_add = {res_q[W-1], res_q} + {num_tc[W-1], num_tc};
  assign sum_sub = {res_q[W-1], res_q} - {num_tc[W-1], num_tc};
  assign add_ovf = sum_add[W] ^ sum_add[W-1];
  assign sub_ovf = sum_sub[W] ^ sum_sub[W-1];

  // Restoring-division trial subtraction.
  assign rem_sh = {z_q[W-1:0], y_q[W-1]};
  assign dvs    = {1'b0, x_q[W-1:0]};
  assign rem_ge = rem_sh >= dvs;

  // Final sign application and range check once the iteration is done.
  assign fin_mag = (op_q == OpMul) ? z_q : {{W{1'b0}}, y_q};
  assign fin_ovf = neg_q ? (fin_mag > NegLim) : (fin_mag > PosLim);
  assign fin_val = neg_q ? -fin_mag[W-1:0] : fin_mag[W-1:0];

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    btn_d   = btn_now;
    res_d   = res_q;
    ovf_d   = ovf_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (rise[4]) begin
          res_d = num_tc;
        end else if (op_pressed) begin
          op_d    = op_sel;
          state_d = StOpsel;
        end
      end
      StOpsel: begin
        if (rise[4]) begin
          case (op_q)
            OpAdd, OpSub: begin
              op_d = OpNone;
              if ((op_q == OpAdd) ? add_ovf : sub_ovf) begin
                ovf_d   = 1'b1;
                state_d = StErr;
              end else begin
                res_d   = (op_q == OpAdd) ? sum_add[W-1:0] : sum_sub[W-1:0];
                state_d = StIdle;
              end
            end
            OpMul: begin
              x_d     = {{W{1'b0}}, a_mag};
              y_d     = num_mag;
              z_d     = '0;
              neg_d   = res_q[W-1] ^ bus.Number[W-1];
              cnt_d   = '0;
              state_d = StBusy;
            end
            OpDiv: begin
              if (num_mag == '0) begin
                op_d    = OpNone;
                ovf_d   = 1'b1;
                state_d = StErr;
              end else begin
                x_d     = {{W{1'b0}}, num_mag};
                y_d     = a_mag;
                z_d     = '0;
                neg_d   = res_q[W-1] ^ bus.Number[W-1];
                cnt_d   = '0;
                state_d = StBusy;
              end
            end
            default: state_d = StIdle;
          endcase
        end else if (op_pressed) begin
          op_d = op_sel;
        end
      end
      StBusy: begin
        if (cnt_q == CntW'(W)) begin
          op_d = OpNone;
          if (fin_ovf) begin
            ovf_d   = 1'b1;
            state_d = StErr;
          end else begin
            res_d   = fin_val;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (op_q == OpMul) begin
            if (y_q[0]) z_d = z_q + x_q;
            x_d = x_q << 1;
            y_d = y_q >> 1;
          end else if (rem_ge) begin
            z_d = {{(W-1){1'b0}}, rem_sh - dvs};
            y_d = {y_q[W-2:0], 1'b1};
          end else begin
            z_d = {{(W-1){1'b0}}, rem_sh};
            y_d = {y_q[W-2:0], 1'b0};
          end
        end
      end
      StErr: ;
      default: state_d = StIdle;
    endcase
  end

  // State register; Clear wins over everything, including an in-flight mul/div.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= StIdle;
      op_q    <= OpNone;
      btn_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      btn_q   <= btn_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Result   = res_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_four_func_calc_core.sv
// Bench for four_func_calc_core: integer-arithmetic reference model checked every cycle,
// plus hand-computed expectations along the directed sequence.
module tb_four_func_calc_core;
  localparam int W      = 11;
  localparam int NEGLIM = -(1 << (W - 1));
  localparam int POSLIM = (1 << (W - 1)) - 1;
  localparam logic [4:0] B_EQ  = 5'b10000;
  localparam logic [4:0] B_ADD = 5'b01000;
  localparam logic [4:0] B_SUB = 5'b00100;
  localparam logic [4:0] B_MUL = 5'b00010;
  localparam logic [4:0] B_DIV = 5'b00001;
  localparam int M_IDLE = 0, M_OPSEL = 1, M_BUSY = 2, M_ERR = 3;
  localparam int OP_ADD = 1, OP_SUB = 2, OP_MUL = 3, OP_DIV = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  four_func_calc_core_if #(.W(W)) bus ();

  four_func_calc_core #(.W(W)) dut (
    .Clock (clk),
    .Clear (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int       m_res = 0;
  bit       m_ovf = 1'b0;
  int       m_st  = M_IDLE;
  int       m_op  = 0;
  int       m_cnt = 0;
  int       m_pend = 0;
  bit [4:0] m_prev = '0;

  function automatic int tc(input logic [W-1:0] n);
    int mag;
    mag = int'(n[W-2:0]);
    return n[W-1] ? -mag : mag;
  endfunction

  function automatic bit in_range(input int v);
    return (v >= NEGLIM) && (v <= POSLIM);
  endfunction

  function automatic int prio(input bit [4:0] r);
    if (r[3]) return OP_ADD;
    if (r[2]) return OP_SUB;
    if (r[1]) return OP_MUL;
    return OP_DIV;
  endfunction

  function automatic logic [W-1:0] sm(input bit neg, input int mag);
    logic [W-1:0] v;
    v = W'(mag);
    v[W-1] = neg;
    return v;
  endfunction

  initial begin
    bit [4:0] b, r;
    int a, n, ans;
    forever begin
      @(posedge clk);
      b = {bus.Equals, bus.Add, bus.Subtract, bus.Multiply, bus.Divide};
      r = b & ~m_prev;
      m_prev = b;
      n = tc(bus.Number);
      a = m_res;
      if (clr) begin
        m_res = 0; m_ovf = 0; m_st = M_IDLE; m_op = 0; m_prev = '0;
      end else begin
        case (m_st)
          M_IDLE: begin
            if (r[4]) m_res = n;
            else if (|r[3:0]) begin m_op = prio(r); m_st = M_OPSEL; end
          end
          M_OPSEL: begin
            if (r[4]) begin
              case (m_op)
                OP_ADD:  ans = a + n;
                OP_SUB:  ans = a - n;
                OP_MUL:  ans = a * n;
                default: ans = (n == 0) ? 0 : a / n;
              endcase
              if (m_op == OP_DIV && n == 0) begin
                m_ovf = 1; m_st = M_ERR;
              end else if (m_op == OP_ADD || m_op == OP_SUB) begin
                if (in_range(ans)) begin m_res = ans; m_st = M_IDLE; end
                else begin m_ovf = 1; m_st = M_ERR; end
              end else begin
                m_pend = ans; m_cnt = W; m_st = M_BUSY;
              end
            end else if (|r[3:0]) m_op = prio(r);
          end
          M_BUSY: begin
            if (m_cnt == 0) begin
              if (in_range(m_pend)) begin m_res = m_pend; m_st = M_IDLE; end
              else begin m_ovf = 1; m_st = M_ERR; end
            end else m_cnt = m_cnt - 1;
          end
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    int act;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        act = $signed(bus.Result);
        n_tests++;
        if (act !== m_res || bus.Overflow !== m_ovf) begin
          n_fail++;
          $display("FAIL model t=%0t: Result=%0d Overflow=%0b, required Result=%0d Overflow=%0b",
                   $time, act, bus.Overflow, m_res, m_ovf);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int exp_res, input int exp_ovf);
    chk({name, " result"}, $signed(bus.Result), exp_res);
    chk({name, " overflow"}, int'(bus.Overflow), exp_ovf);
  endtask

  task automatic press(input logic [4:0] btns, input logic [W-1:0] num, input int hold);
    {bus.Equals, bus.Add, bus.Subtract, bus.Multiply, bus.Divide} = btns;
    bus.Number = num;
    repeat (hold) @(negedge clk);
    {bus.Equals, bus.Add, bus.Subtract, bus.Multiply, bus.Divide} = '0;
    @(negedge clk);
  endtask

  task automatic eq(input logic [W-1:0] num);
    press(B_EQ, num, 1);
  endtask

  task automatic do_clear(input int cycles);
    clr = 1'b1;
    repeat (cycles) @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    {bus.Equals, bus.Add, bus.Subtract, bus.Multiply, bus.Divide} = '0;
    bus.Number = '0;
    // 1: reset, load, multiply by zero
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk_out("reset", 0, 0);
    eq(11'd3);             chk_out("load 3", 3, 0);
    press(B_MUL, 0, 2);
    eq(11'd0);
    repeat (W) @(negedge clk);
    chk_out("3x0", 0, 0);

    // 2: chained adds, held button, no repeat on Equals
    eq(11'd1);             chk_out("load 1", 1, 0);
    press(B_ADD, 0, 1); eq(11'd2); chk_out("1+2", 3, 0);
    press(B_ADD, 0, 1); eq(11'd2); chk_out("3+2", 5, 0);
    press(B_ADD, 0, 20); eq(11'd2); chk_out("held add", 7, 0);
    eq(11'd9);             chk_out("reload 9", 9, 0);

    // 3: sign-magnitude inputs
    eq(11'h405);           chk_out("load -5", -5, 0);
    press(B_SUB, 0, 1); eq(11'd7); chk_out("-5-7", -12, 0);
    eq(11'h400);           chk_out("neg zero", 0, 0);

    // Priority and operator replacement
    press(B_EQ | B_ADD, 11'd6, 1); chk_out("eq beats add", 6, 0);
    eq(11'd2);             chk_out("no pending add", 2, 0);
    eq(11'd10);
    press(B_ADD, 0, 1); press(B_SUB, 0, 1); eq(11'd4); chk_out("op replaced", 6, 0);
    eq(11'd3);
    press(B_MUL | B_DIV, 0, 1); eq(11'd2);
    repeat (W) @(negedge clk);
    chk_out("mul beats div", 6, 0);

    // 4: multiply/divide, with latency edge
    eq(11'd32);
    press(B_MUL, 0, 1); eq(sm(1, 32));
    repeat (W - 1) @(negedge clk);
    chk_out("32x-32 early", 32, 0);
    @(negedge clk);
    chk_out("32x-32", -1024, 0);
    eq(sm(1, 7)); press(B_DIV, 0, 1); eq(11'd2);
    repeat (W) @(negedge clk);
    chk_out("-7/2", -3, 0);
    eq(11'd7); press(B_DIV, 0, 1); eq(sm(1, 7));
    repeat (W) @(negedge clk);
    chk_out("7/-7", -1, 0);
    eq(11'd32); press(B_MUL, 0, 1); eq(11'd32);
    repeat (W) @(negedge clk);
    chk_out("32x32", 32, 1);
    do_clear(1);

    // 5: add overflow, ignored buttons in ERR, divide by zero
    eq(11'd1000); press(B_ADD, 0, 1); eq(11'd100);
    chk_out("1000+100", 1000, 1);
    eq(11'd5);             chk_out("err ignores eq", 1000, 1);
    press(B_ADD, 0, 1); eq(11'd1); chk_out("err ignores add", 1000, 1);
    do_clear(1);           chk_out("clear err", 0, 0);
    eq(11'd7); press(B_DIV, 0, 1); eq(11'd0);
    chk_out("7/0", 7, 1);
    do_clear(1);

    // 6: Clear during a multiply
    eq(11'd5); press(B_MUL, 0, 1); eq(11'd3);
    repeat (3) @(negedge clk);
    do_clear(1);           chk_out("clear mid busy", 0, 0);
    eq(11'd4);             chk_out("load after clear", 4, 0);
    repeat (W + 3) @(negedge clk);
    chk_out("no late write", 4, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
